// File: rtl/d_serial_m_lfs_remainder_chk.sv
// ---------------------------------------------------------------------------
// d_serial_m_lfs_remainder_chk
//
// Serial BCH codeword checker. Received codeword bits (message first, then
// parity, highest-order coefficient first) are shifted one per transfer
// through the generator-polynomial LFSR. After the last bit the remainder is
// x^PRT_BITS * c(x) mod g(x), which is zero exactly when the codeword is a
// multiple of g(x). A zero result lets the rest of the decoder be skipped.
//
// Optional build macro:
//   D_BCH_CHK_REMAINDER_OUT_EN - exposes the final remainder on o_remainder
//                                while o_chk_valid is high (zero otherwise).
// ---------------------------------------------------------------------------
module d_serial_m_lfs_remainder_chk #(
  parameter int                MSG_BITS = 8192,
  parameter int                PRT_BITS = 168,
  parameter logic [0:PRT_BITS] G_POLY   = 169'b1100011001001101001001011010010000001010100100010101010000111100111110110010110000100000001101100011000011111011010100011001110110100011110100100001001101010100010111001
) (
  input  logic                i_clk,
  input  logic                i_nRESET,
  input  logic                i_bit_valid,
  input  logic                i_bit,
  output logic                o_bit_ready,
  output logic                o_chk_valid,
  output logic                o_chk_error,
  input  logic                i_chk_ready,
  output logic                o_busy
`ifdef D_BCH_CHK_REMAINDER_OUT_EN
  ,
  output logic [PRT_BITS-1:0] o_remainder
`endif
);

  // Codeword length and bit-counter sizing. The counter never wraps inside a
  // frame: it parks on the last index until the result is consumed.
  localparam int CW_BITS = MSG_BITS + PRT_BITS;
  localparam int CNT_W   = (CW_BITS > 1) ? $clog2(CW_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CW_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // waiting for the first bit of a frame
    RUN  = 2'd1,   // frame in progress
    OUT  = 2'd2    // result held until the consumer takes it
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PRT_BITS-1:0] rem;
  logic [PRT_BITS-1:0] rem_step;
  logic [CNT_W-1:0]    cnt;
  logic                fb;
  logic                take;
  logic                consume;
  logic                last_bit;

  // A bit moves only when both sides agree; o_bit_ready is low in OUT, so a
  // transfer and a result hand-off can never happen on the same edge.
  assign take     = i_bit_valid & o_bit_ready;
  assign consume  = (state == OUT) & i_chk_ready;
  assign last_bit = (cnt == LAST_CNT);

  // One LFSR step of the remainder for the bit currently presented.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    rem_step    = '0;
    fb          = i_bit ^ rem[PRT_BITS-1];
    rem_step[0] = fb;
    for (int i = 1; i < PRT_BITS; i++) begin
      rem_step[i] = rem[i-1] ^ (G_POLY[i] & fb);
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_nRESET) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!i_nRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode. A one-bit codeword finishes on the IDLE transfer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_nxt = last_bit ? OUT : RUN;
        end
      end
      RUN: begin
        if (take && last_bit) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (i_chk_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remainder register: advances on each transfer, cleared on hand-off.
  // It is zero in IDLE, so the first step naturally starts from rem = 0.
  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      rem <= '0;
    end else if (take) begin
      rem <= rem_step;
    end else if (consume) begin
      rem <= '0;
    end
  end

  // Bit counter: 0..CW_BITS-1, parked on the last index while in OUT.
  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      cnt <= '0;
    end else if (take) begin
      if (!last_bit) begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (consume) begin
      cnt <= '0;
    end
  end

  // Error flag: captured from the post-step remainder on the final bit and
  // held for as long as the result waits in OUT.
  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      o_chk_error <= 1'b0;
    end else if (take && last_bit) begin
      o_chk_error <= |rem_step;
    end else if (consume) begin
      o_chk_error <= 1'b0;
    end
  end

  // Registered handshake/status outputs, decoded from the next state so they
  // line up with the state they describe and are all low during reset.
  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      o_bit_ready <= 1'b0;
      o_chk_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_bit_ready <= (state_nxt != OUT);
      o_chk_valid <= (state_nxt == OUT);
      o_busy      <= (state_nxt != IDLE);
    end
  end

`ifdef D_BCH_CHK_REMAINDER_OUT_EN
  // Final remainder for a later syndrome stage; forced to zero outside OUT so
  // the partial remainder of a running frame is never visible.
  assign o_remainder = o_chk_valid ? rem : '0;
`endif

endmodule

// File: tb/tb_d_serial_m_lfs_remainder_chk.sv
// ---------------------------------------------------------------------------
// Bench for d_serial_m_lfs_remainder_chk. Codewords are built and checked
// with plain polynomial long division over GF(2) on bit arrays; the DUT's
// error flag (and remainder, when D_BCH_CHK_REMAINDER_OUT_EN is defined) is
// compared against that model and against the expected outcome of each case.
// ---------------------------------------------------------------------------
module tb_d_serial_m_lfs_remainder_chk;

  localparam int M          = 8192;
  localparam int P          = 168;
  localparam int N          = M + P;
  localparam int NP         = N + P;
  localparam int BIT_BUDGET = 16;
  localparam logic [0:P] G_POLY = 169'b1100011001001101001001011010010000001010100100010101010000111100111110110010110000100000001101100011000011111011010100011001110110100011110100100001001101010100010111001;

  logic i_clk = 1'b0;
  logic i_nRESET;
  logic i_bit_valid;
  logic i_bit;
  logic o_bit_ready;
  logic o_chk_valid;
  logic o_chk_error;
  logic i_chk_ready;
  logic o_busy;
`ifdef D_BCH_CHK_REMAINDER_OUT_EN
  logic [P-1:0] o_remainder;
`endif

  d_serial_m_lfs_remainder_chk #(
    .MSG_BITS (M),
    .PRT_BITS (P),
    .G_POLY   (G_POLY)
  ) dut (
    .i_clk       (i_clk),
    .i_nRESET    (i_nRESET),
    .i_bit_valid (i_bit_valid),
    .i_bit       (i_bit),
    .o_bit_ready (o_bit_ready),
    .o_chk_valid (o_chk_valid),
    .o_chk_error (o_chk_error),
    .i_chk_ready (i_chk_ready),
    .o_busy      (o_busy)
`ifdef D_BCH_CHK_REMAINDER_OUT_EN
    ,
    .o_remainder (o_remainder)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef enum int {MSG_ZERO, MSG_FIRST, MSG_RAND} msg_kind_t;

  typedef struct {
    msg_kind_t kind;     // message content
    int        flip;     // codeword bit index to flip, -1 for none
    bit        gap;      // idle cycle after every bit
    int        hold;     // cycles the result is left unconsumed
    bit        exp_err;  // expected o_chk_error
  } vec_t;

  bit msg  [M];
  bit cw   [N];
  bit work [NP];

  int n_checks = 0;
  int n_pass   = 0;
  bit stuck    = 1'b0;

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // work[top:0] holds a dividend (work[j] = coefficient of x^j); reduce mod g.
  task automatic mod_g(input int top, output logic [P-1:0] r);
    for (int j = top; j >= P; j--) begin
      if (work[j]) begin
        for (int t = 0; t <= P; t++) work[j-P+t] = work[j-P+t] ^ bit'(G_POLY[t]);
      end
    end
    for (int i = 0; i < P; i++) r[i] = work[i];
  endtask

  task automatic make_msg(input msg_kind_t kind);
    for (int k = 0; k < M; k++) begin
      case (kind)
        MSG_ZERO:  msg[k] = 1'b0;
        MSG_FIRST: msg[k] = (k == 0);
        default:   msg[k] = 1'($urandom);
      endcase
    end
  endtask

  // Systematic encoding: parity = m(x)*x^P mod g(x), sent highest order first.
  task automatic encode();
    logic [P-1:0] r;
    foreach (work[j]) work[j] = 1'b0;
    for (int k = 0; k < M; k++) work[M-1-k+P] = msg[k];
    mod_g(M + P - 1, r);
    for (int k = 0; k < M; k++) cw[k] = msg[k];
    for (int i = 0; i < P; i++) cw[M+i] = r[P-1-i];
  endtask

  // Expected final remainder: x^P * c(x) mod g(x).
  task automatic model_rem(output logic [P-1:0] r);
    foreach (work[j]) work[j] = 1'b0;
    for (int k = 0; k < N; k++) work[N-1-k+P] = cw[k];
    mod_g(NP - 1, r);
  endtask

  // Present one bit until accepted; waited = idle cycles, -1 on timeout.
  task automatic send_bit(input logic b, output int waited);
    waited = 0;
    if (stuck) begin
      waited = -1;
      return;
    end
    i_bit_valid = 1'b1;
    i_bit       = b;
    forever begin
      @(negedge i_clk);
      if (o_bit_ready) break;
      waited++;
      if (waited > BIT_BUDGET) begin
        stuck  = 1'b1;
        waited = -1;
        break;
      end
    end
    if (waited >= 0) begin
      @(posedge i_clk);
      #1;
    end
    i_bit_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input bit gap, input int hold,
                           input bit exp_err, input bit consume, output int first_wait);
    logic [P-1:0] exp_rem;
    int           w;
    int           stalls;
    int           hold_bad;
    bit           early;
    stalls     = 0;
    hold_bad   = 0;
    early      = 1'b0;
    first_wait = 0;
    model_rem(exp_rem);
    i_chk_ready = (hold == 0);
    for (int k = 0; k < N; k++) begin
      send_bit(cw[k], w);
      if (w < 0) stalls++;
      if (k == 0) first_wait = w;
      if (k < N - 1 && o_chk_valid) early = 1'b1;
      if (gap && k < N - 1 && !stuck) begin
        i_bit = 1'($urandom);
        @(posedge i_clk);
        #1;
      end
    end
    check({name, "_accept_timeouts"}, P'(stalls), '0);
    check({name, "_no_early_valid"}, P'(early), '0);
    check({name, "_valid_on_last"}, P'(o_chk_valid), P'(1));
    check({name, "_error"}, P'(o_chk_error), P'(exp_err));
    check({name, "_error_vs_model"}, P'(o_chk_error), P'(|exp_rem));
    check({name, "_ready_low"}, P'(o_bit_ready), '0);
    check({name, "_busy"}, P'(o_busy), P'(1));
`ifdef D_BCH_CHK_REMAINDER_OUT_EN
    check({name, "_remainder"}, o_remainder, exp_rem);
`endif
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge i_clk);
        #1;
        if (o_chk_valid !== 1'b1 || o_chk_error !== exp_err ||
            o_bit_ready !== 1'b0 || o_busy !== 1'b1) hold_bad++;
`ifdef D_BCH_CHK_REMAINDER_OUT_EN
        if (o_remainder !== exp_rem) hold_bad++;
`endif
      end
      check({name, "_hold_stable"}, P'(hold_bad), '0);
      i_chk_ready = 1'b1;
    end
    if (consume) begin
      @(posedge i_clk);
      #1;
      check({name, "_valid_dropped"}, P'(o_chk_valid), '0);
      check({name, "_idle_not_busy"}, P'(o_busy), '0);
      check({name, "_idle_ready"}, P'(o_bit_ready), P'(1));
`ifdef D_BCH_CHK_REMAINDER_OUT_EN
      check({name, "_remainder_cleared"}, o_remainder, '0);
`endif
    end
  endtask

  initial begin
    vec_t vecs [4];
    int   w;
    int   stalls;

    vecs[0] = '{MSG_ZERO,  -1,    1'b0, 0,  1'b0};  // all-zero codeword
    vecs[1] = '{MSG_FIRST, -1,    1'b0, 0,  1'b0};  // single 1 in first message bit
    vecs[2] = '{MSG_FIRST, N - 1, 1'b0, 0,  1'b1};  // same, last parity bit flipped
    vecs[3] = '{MSG_RAND,  -1,    1'b1, 10, 1'b0};  // gapped input, delayed consume

    i_nRESET    = 1'b0;
    i_bit_valid = 1'b0;
    i_bit       = 1'b0;
    i_chk_ready = 1'b0;

    #2;
    check("reset_ready", P'(o_bit_ready), '0);
    check("reset_valid", P'(o_chk_valid), '0);
    check("reset_error", P'(o_chk_error), '0);
    check("reset_busy", P'(o_busy), '0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_nRESET = 1'b1;
    @(posedge i_clk);
    #1;
    check("post_reset_ready", P'(o_bit_ready), P'(1));
    check("post_reset_busy", P'(o_busy), '0);

    for (int i = 0; i < 4; i++) begin
      make_msg(vecs[i].kind);
      encode();
      if (vecs[i].flip >= 0) cw[vecs[i].flip] = ~cw[vecs[i].flip];
      run_frame($sformatf("vec%0d", i), vecs[i].gap, vecs[i].hold, vecs[i].exp_err, 1'b1, w);
    end

    // Reset in the middle of a corrupted frame, then a clean frame.
    make_msg(MSG_RAND);
    encode();
    for (int f = 0; f < 4; f++) begin
      w = $urandom_range(0, 4999);
      cw[w] = ~cw[w];
    end
    i_chk_ready = 1'b1;
    stalls = 0;
    for (int k = 0; k < 5000; k++) begin
      send_bit(cw[k], w);
      if (w < 0) stalls++;
    end
    check("midframe_accept_timeouts", P'(stalls), '0);
    check("midframe_busy", P'(o_busy), P'(1));
    #2;
    i_nRESET = 1'b0;
    #1;
    check("midreset_ready", P'(o_bit_ready), '0);
    check("midreset_valid", P'(o_chk_valid), '0);
    check("midreset_error", P'(o_chk_error), '0);
    check("midreset_busy", P'(o_busy), '0);
`ifdef D_BCH_CHK_REMAINDER_OUT_EN
    check("midreset_remainder", o_remainder, '0);
`endif
    repeat (2) @(posedge i_clk);
    #1;
    check("midreset_held_valid", P'(o_chk_valid), '0);
    @(negedge i_clk);
    i_nRESET = 1'b1;
    make_msg(MSG_RAND);
    encode();
    run_frame("after_reset", 1'b0, 0, 1'b0, 1'b1, w);

    // Back-to-back frames; the second has message bit 0 corrupted.
    make_msg(MSG_RAND);
    encode();
    run_frame("b2b_first", 1'b0, 0, 1'b0, 1'b0, w);
    make_msg(MSG_RAND);
    encode();
    cw[0] = ~cw[0];
    run_frame("b2b_second", 1'b0, 0, 1'b1, 1'b1, w);
    check("b2b_gap_cycles", P'(w), P'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
